// File: rtl/zjh_prio_irq_enc.sv
// Registered 74HC148-style priority encoder with masking, optional falling-edge
// pending capture and a hold/acknowledge handshake on the encoded code.
module zjh_prio_irq_enc #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter bit EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EI,
  input  logic [N-1:0] DataIn,
  input  logic [N-1:0] Mask,
  input  logic         Ack,
  output logic [W-1:0] Dataout,
  output logic         GS,
  output logic         EO
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e       state_q;
  logic [N-1:0] din_q, din_qq;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] req, fell;
  logic         any_req;

  always_comb begin
    fell    = din_qq & ~din_q;
    req     = EDGE ? (pend_q & ~Mask) : (~din_q & ~Mask);
    any_req = |req;
    idx_d   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx_d = W'(i);
    end

    // Clear of the acknowledged line is applied first so a coincident new edge wins.
    pend_d = pend_q;
    if (!EI && state_q == HOLD && Ack) pend_d[idx_q] = 1'b0;
    pend_d = pend_d | fell;
    if (!EDGE) pend_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q   <= '1;
      din_qq  <= '1;
      pend_q  <= '0;
      idx_q   <= '0;
      state_q <= IDLE;
      Dataout <= '1;
      GS      <= 1'b1;
      EO      <= 1'b1;
    end else begin
      din_q  <= DataIn;
      din_qq <= din_q;
      pend_q <= pend_d;
      if (EI) begin
        state_q <= IDLE;
        Dataout <= '1;
        GS      <= 1'b1;
        EO      <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (any_req) begin
              state_q <= HOLD;
              idx_q   <= idx_d;
              Dataout <= ~idx_d;
              GS      <= 1'b0;
              EO      <= 1'b1;
            end else begin
              Dataout <= '1;
              GS      <= 1'b1;
              EO      <= 1'b0;
            end
          end
          HOLD: begin
            // Leaving HOLD always passes through one IDLE cycle before the next grant.
            if (Ack) begin
              state_q <= IDLE;
              Dataout <= '1;
              GS      <= 1'b1;
              EO      <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zjh_prio_irq_enc.sv
// Directed bench: one level-mode and one edge-mode encoder instance.
module tb_zjh_prio_irq_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       ei0, ack0, ei1, ack1;
  logic [7:0] din0, mask0, din1, mask1;
  logic [2:0] dout0, dout1;
  logic       gs0, eo0, gs1, eo1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zjh_prio_irq_enc #(.N(8), .EDGE(1'b0)) u_lvl (
    .clk(clk), .rst(rst), .EI(ei0), .DataIn(din0), .Mask(mask0), .Ack(ack0),
    .Dataout(dout0), .GS(gs0), .EO(eo0)
  );

  zjh_prio_irq_enc #(.N(8), .EDGE(1'b1)) u_edg (
    .clk(clk), .rst(rst), .EI(ei1), .DataIn(din1), .Mask(mask1), .Ack(ack1),
    .Dataout(dout1), .GS(gs1), .EO(eo1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ei0 = 1'b0; ack0 = 1'b0; din0 = 8'hFF; mask0 = 8'h00;
    ei1 = 1'b0; ack1 = 1'b0; din1 = 8'hFF; mask1 = 8'h00;
    tick(); tick();
    check("rst_dout0", dout0, 3'b111);
    check("rst_gs0", gs0, 1'b1);
    check("rst_eo0", eo0, 1'b1);
    check("rst_gs1", gs1, 1'b1);
    check("rst_eo1", eo1, 1'b1);
    rst = 1'b0;
    tick(); tick();
    check("idle_dout0", dout0, 3'b111);
    check("idle_gs0", gs0, 1'b1);
    check("idle_eo0", eo0, 1'b0);

    // Level mode: bits 5 and 2 low
    din0 = 8'b1101_1011;
    tick();
    check("lvl_latency_gs", gs0, 1'b1);
    tick();
    check("lvl_dout5", dout0, 3'b010);
    check("lvl_gs5", gs0, 1'b0);
    check("lvl_eo5", eo0, 1'b1);
    din0 = 8'b0111_1111;
    tick(); tick();
    check("hold_dout", dout0, 3'b010);
    check("hold_gs", gs0, 1'b0);
    ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("ack_gs", gs0, 1'b1);
    check("ack_dout", dout0, 3'b111);
    check("ack_eo_not_with_gs", eo0, 1'b1);
    tick();
    check("lvl_dout7", dout0, 3'b000);
    check("lvl_gs7", gs0, 1'b0);

    // Mask bit 5 with bits 5,2 low -> grant 2
    din0 = 8'b1101_1011; mask0 = 8'h20; ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    check("mask_idle_gs", gs0, 1'b1);
    tick();
    check("mask_dout2", dout0, 3'b101);
    check("mask_gs2", gs0, 1'b0);

    // EI forcing inactive during HOLD, then re-grant
    mask0 = 8'h00; ack0 = 1'b1;
    tick();
    ack0 = 1'b0;
    tick();
    check("unmask_dout5", dout0, 3'b010);
    ei0 = 1'b1;
    tick();
    check("ei_gs0", gs0, 1'b1);
    check("ei_eo0", eo0, 1'b1);
    check("ei_dout0", dout0, 3'b111);
    ei0 = 1'b0;
    tick();
    check("ei_regrant0", dout0, 3'b010);
    check("ei_regrant_gs0", gs0, 1'b0);

    // Edge mode: pulses captured while disabled, then served by priority
    ei1 = 1'b1;
    din1 = 8'hF7; tick();
    din1 = 8'hBF; tick();
    din1 = 8'hFF; tick();
    tick();
    check("edge_ei_gs", gs1, 1'b1);
    ei1 = 1'b0;
    tick();
    check("edge_dout6", dout1, 3'b001);
    check("edge_gs6", gs1, 1'b0);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("edge_ack6_gs", gs1, 1'b1);
    tick();
    check("edge_dout3", dout1, 3'b100);
    check("edge_gs3", gs1, 1'b0);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("edge_ack3_gs", gs1, 1'b1);
    tick();
    check("edge_empty_gs", gs1, 1'b1);
    check("edge_empty_eo", eo1, 1'b0);
    check("edge_empty_dout", dout1, 3'b111);

    // Ack and new falling edge on bit 4 in the same cycle
    din1 = 8'hEF; tick();
    din1 = 8'hFF; tick();
    tick();
    check("edge_dout4", dout1, 3'b011);
    din1 = 8'hEF; tick();
    din1 = 8'hFF; ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("setwins_idle_gs", gs1, 1'b1);
    tick();
    check("setwins_dout4", dout1, 3'b011);
    check("setwins_gs4", gs1, 1'b0);

    // EI in HOLD keeps the pending line
    ei1 = 1'b1;
    tick();
    check("edge_ei_gs1", gs1, 1'b1);
    check("edge_ei_eo1", eo1, 1'b1);
    check("edge_ei_dout1", dout1, 3'b111);
    ei1 = 1'b0;
    tick();
    check("edge_ei_regrant", dout1, 3'b011);
    check("edge_ei_regrant_gs", gs1, 1'b0);

    // Reset in HOLD drops pending state
    rst = 1'b1;
    tick();
    check("midrst_gs", gs1, 1'b1);
    check("midrst_eo", eo1, 1'b1);
    check("midrst_dout", dout1, 3'b111);
    rst = 1'b0;
    tick(); tick(); tick();
    check("postrst_gs", gs1, 1'b1);
    check("postrst_eo", eo1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
